// File: rtl/sram_rr_arbiter.sv
`timescale 1ns/1ps
// sram_rr_arbiter
// Round-robin arbiter and access sequencer for one asynchronous SRAM shared by
// two Avalon-style masters (m0: SoC conduit, m1: test runner).
// Each accepted request runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE.
//
// Ports:
//   clock, reset_n          single clock, synchronous active-low reset
//   excl                    high: m0 requests are masked (sampled in IDLE only)
//   mN_address/byteenable/read/write/writedata   master request inputs
//   mN_readdata             shared read-data register
//   mN_readdataready        one-cycle pulse in DONE of a read
//   mN_waitrequest          low only during the DONE cycle of that master's grant
//   busy                    FSM not in IDLE
//   sram_*                  SRAM pins; sram_data driven only for writes
module sram_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    excl,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic                    m0_readdataready,
  output logic                    m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m1_readdataready,
  output logic                    m1_waitrequest,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   sram_address,
  inout  wire  [DATA_WIDTH-1:0]   sram_data,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam int unsigned CW   = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WCNT_INIT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                state_q;
  logic [CW-1:0]         wcnt_q;
  logic                  last_q;
  logic                  gnt_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BE_W-1:0]       be_n_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive_q;
  logic                  ce_n_q;
  logic                  oe_n_q;
  logic                  we_n_q;
  logic                  wait0_q;
  logic                  wait1_q;
  logic                  rdv0_q;
  logic                  rdv1_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Arbitration decision, consumed only by the IDLE branch of the FSM.
  logic                  req0_d;
  logic                  req1_d;
  logic                  gnt_valid_d;
  logic                  gnt_d;
  logic                  sel_write_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [BE_W-1:0]       sel_be_d;
  logic [DATA_WIDTH-1:0] sel_wdata_d;

  always_comb begin
    req0_d      = (m0_read | m0_write) & ~excl;
    req1_d      = m1_read | m1_write;
    gnt_valid_d = req0_d | req1_d;
    // Tie goes to the master not served last; otherwise the lone requester.
    gnt_d       = (req0_d & req1_d) ? ~last_q : req1_d;
    sel_write_d = gnt_d ? m1_write      : m0_write;
    sel_addr_d  = gnt_d ? m1_address    : m0_address;
    sel_be_d    = gnt_d ? m1_byteenable : m0_byteenable;
    sel_wdata_d = gnt_d ? m1_writedata  : m0_writedata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_n_q  <= '1;
      wdata_q <= '0;
      drive_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      wait0_q <= 1'b1;
      wait1_q <= 1'b1;
      rdv0_q  <= 1'b0;
      rdv1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            state_q <= ACCESS;
            wcnt_q  <= WCNT_INIT;
            gnt_q   <= gnt_d;
            wr_q    <= sel_write_d;
            addr_q  <= sel_addr_d;
            be_n_q  <= ~sel_be_d;
            wdata_q <= sel_wdata_d;
            drive_q <= sel_write_d;
            ce_n_q  <= 1'b0;
            oe_n_q  <= sel_write_d;
            we_n_q  <= ~sel_write_d;
          end
        end
        ACCESS: begin
          if (wcnt_q == '0) begin
            state_q <= DONE;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            wait0_q <= gnt_q;
            wait1_q <= ~gnt_q;
            rdv0_q  <= ~wr_q & ~gnt_q;
            rdv1_q  <= ~wr_q & gnt_q;
            if (!wr_q) begin
              rdata_q <= sram_data;
            end
          end else begin
            wcnt_q <= wcnt_q - CW'(1);
          end
        end
        DONE: begin
          // ce_n, address and write data were held through DONE for hold time.
          state_q <= IDLE;
          last_q  <= gnt_q;
          ce_n_q  <= 1'b1;
          drive_q <= 1'b0;
          wait0_q <= 1'b1;
          wait1_q <= 1'b1;
          rdv0_q  <= 1'b0;
          rdv1_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_data        = drive_q ? wdata_q : 'z;
  assign sram_address     = addr_q;
  assign sram_be_n        = be_n_q;
  assign sram_ce_n        = ce_n_q;
  assign sram_oe_n        = oe_n_q;
  assign sram_we_n        = we_n_q;
  assign busy             = (state_q != IDLE);
  assign m0_waitrequest   = wait0_q;
  assign m1_waitrequest   = wait1_q;
  assign m0_readdataready = rdv0_q;
  assign m1_readdataready = rdv1_q;
  assign m0_readdata      = rdata_q;
  assign m1_readdata      = rdata_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
`timescale 1ns/1ps
module tb_sram_rr_arbiter;

  localparam int W = 2;

  typedef struct {
    bit          v;
    bit          rd;
    bit          wr;
    logic [19:0] a;
    logic [1:0]  be;
    logic [15:0] d;
  } req_t;

  int checks = 0;
  int errors = 0;
  bit model_last = 1'b1;

  logic clock = 1'b0;
  logic reset_n, excl, mem_init;
  logic [19:0] m0_address, m1_address;
  logic [1:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata;
  logic [15:0] m0_readdata, m1_readdata;
  logic        m0_readdataready, m1_readdataready, m0_waitrequest, m1_waitrequest;
  logic        busy, sram_ce_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_address;
  logic [1:0]  sram_be_n;
  wire  [15:0] sram_data;

  logic [19:0] b_m0_address;
  logic [1:0]  b_m0_byteenable;
  logic        b_m0_read, b_m0_write;
  logic [15:0] b_m0_writedata;
  logic [15:0] b_m0_readdata, b_m1_readdata;
  logic        b_m0_readdataready, b_m1_readdataready, b_m0_waitrequest, b_m1_waitrequest;
  logic        b_busy, b_sram_ce_n, b_sram_oe_n, b_sram_we_n;
  logic [19:0] b_sram_address;
  logic [1:0]  b_sram_be_n;
  wire  [15:0] b_sram_data;

  logic [15:0] sram_mem [0:4095];
  logic [15:0] ref_mem  [0:4095];

  always #5 clock = ~clock;

  sram_rr_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(W)) u_dut (
    .clock(clock), .reset_n(reset_n), .excl(excl),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_readdataready(m0_readdataready), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_readdataready(m1_readdataready), .m1_waitrequest(m1_waitrequest),
    .busy(busy), .sram_address(sram_address), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );

  sram_rr_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(1)) u_dut_w1 (
    .clock(clock), .reset_n(reset_n), .excl(1'b0),
    .m0_address(b_m0_address), .m0_byteenable(b_m0_byteenable), .m0_read(b_m0_read),
    .m0_write(b_m0_write), .m0_writedata(b_m0_writedata), .m0_readdata(b_m0_readdata),
    .m0_readdataready(b_m0_readdataready), .m0_waitrequest(b_m0_waitrequest),
    .m1_address(20'h0), .m1_byteenable(2'b00), .m1_read(1'b0),
    .m1_write(1'b0), .m1_writedata(16'h0), .m1_readdata(b_m1_readdata),
    .m1_readdataready(b_m1_readdataready), .m1_waitrequest(b_m1_waitrequest),
    .busy(b_busy), .sram_address(b_sram_address), .sram_data(b_sram_data),
    .sram_ce_n(b_sram_ce_n), .sram_oe_n(b_sram_oe_n), .sram_we_n(b_sram_we_n),
    .sram_be_n(b_sram_be_n)
  );

  // Power-on SRAM contents; chosen so that word 0x010 holds 0xBEEF.
  function automatic logic [15:0] pat(int unsigned i);
    return 16'(32'hBEEF + (i - 32'd16) * 32'd40503);
  endfunction

  // Asynchronous SRAM model (4K words, address aliased on the low 12 bits).
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_address[11:0]] : 16'hzzzz;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= pat(i);
    end else if (!sram_ce_n && !sram_we_n) begin
      sram_mem[sram_address[11:0]] <= {
        sram_be_n[1] ? sram_mem[sram_address[11:0]][15:8] : sram_data[15:8],
        sram_be_n[0] ? sram_mem[sram_address[11:0]][7:0]  : sram_data[7:0]};
    end
  end

  task automatic ref_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] mask;
    mask = {{8{be[1]}}, {8{be[0]}}};
    ref_mem[a[11:0]] = (ref_mem[a[11:0]] & ~mask) | (d & mask);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    mem_init = 1'b0;
    checks++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdataready, m1_readdataready} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_master_ctl got %b exp 1100",
               {m0_waitrequest, m1_waitrequest, m0_readdataready, m1_readdataready});
    end
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n});
    end
    checks++;
    if (sram_address !== 20'h0 || m0_readdata !== 16'h0 || m1_readdata !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got addr %h rd0 %h rd1 %h busy %b exp 0 0 0 0",
               sram_address, m0_readdata, m1_readdata, busy);
    end
    checks++;
    if ({b_m0_waitrequest, b_sram_ce_n, b_sram_we_n, b_busy} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_w1 got %b exp 1110", {b_m0_waitrequest, b_sram_ce_n, b_sram_we_n, b_busy});
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || m0_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got busy %b wr0 %b exp 0 1", busy, m0_waitrequest);
    end
  endtask

  task automatic test_m0_read();
    m0_address = 20'h00010; m0_byteenable = 2'b11; m0_read = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b001 || sram_address !== 20'h00010 ||
          busy !== 1'b1 || m0_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL m0_read_access c%0d got ce/oe/we %b addr %h busy %b wr0 %b exp 001 00010 1 1",
                 c, {sram_ce_n, sram_oe_n, sram_we_n}, sram_address, busy, m0_waitrequest);
      end
    end
    tick();
    checks++;
    if (m0_waitrequest !== 1'b0 || m0_readdataready !== 1'b1 || m0_readdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL m0_read_done got wr0 %b rdr0 %b data %h exp 0 1 beef",
               m0_waitrequest, m0_readdataready, m0_readdata);
    end
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b011 || m1_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL m0_read_done_strobes got %b wr1 %b exp 011 1",
               {sram_ce_n, sram_oe_n, sram_we_n}, m1_waitrequest);
    end
    m0_read = 1'b0;
    model_last = 1'b0;
    tick();
    checks++;
    if (m0_waitrequest !== 1'b1 || m0_readdataready !== 1'b0 || sram_ce_n !== 1'b1 ||
        busy !== 1'b0 || m0_readdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL m0_read_idle got wr0 %b rdr0 %b ce_n %b busy %b data %h exp 1 0 1 0 beef",
               m0_waitrequest, m0_readdataready, sram_ce_n, busy, m0_readdata);
    end
  endtask

  task automatic test_m1_write();
    int we_cnt = 0;
    int done_c = -1;
    bit rdr_seen = 0;
    m1_address = 20'hFFFFF; m1_byteenable = 2'b01; m1_writedata = 16'h1234; m1_write = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (m1_readdataready) rdr_seen = 1;
      if (!sram_we_n) begin
        we_cnt++;
        checks++;
        if (sram_be_n !== 2'b10 || sram_data !== 16'h1234 || sram_address !== 20'hFFFFF || sram_ce_n !== 1'b0) begin
          errors++;
          $display("FAIL m1_write_access got be_n %b data %h addr %h ce_n %b exp 10 1234 fffff 0",
                   sram_be_n, sram_data, sram_address, sram_ce_n);
        end
      end
      if (!m1_waitrequest && done_c < 0) begin
        done_c = c;
        checks++;
        if (sram_data !== 16'h1234 || sram_ce_n !== 1'b0 || sram_we_n !== 1'b1 || sram_address !== 20'hFFFFF) begin
          errors++;
          $display("FAIL m1_write_hold got data %h ce_n %b we_n %b addr %h exp 1234 0 1 fffff",
                   sram_data, sram_ce_n, sram_we_n, sram_address);
        end
        m1_write = 1'b0;
      end
    end
    ref_write(20'hFFFFF, 16'h1234, 2'b01);
    model_last = 1'b1;
    checks++;
    if (we_cnt !== 2) begin errors++; $display("FAIL m1_write_we_len got %0d exp 2", we_cnt); end
    checks++;
    if (done_c !== W + 1) begin errors++; $display("FAIL m1_write_latency got %0d exp %0d", done_c, W + 1); end
    checks++;
    if (rdr_seen !== 1'b0) begin errors++; $display("FAIL m1_write_rdr got 1 exp 0"); end
  endtask

  task automatic test_contention();
    int gm[$];
    int gc[$];
    bit overlap = 0;
    bit el;
    m0_address = 20'h00020; m1_address = 20'h00030;
    m0_byteenable = 2'b11; m1_byteenable = 2'b11;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int c = 1; c <= 24 && gm.size() < 4; c++) begin
      tick();
      if (!m0_waitrequest && !m1_waitrequest) overlap = 1;
      if (!m0_waitrequest) begin
        gm.push_back(0); gc.push_back(c);
        checks++;
        if (m0_readdataready !== 1'b1 || m0_readdata !== ref_mem[12'h020]) begin
          errors++;
          $display("FAIL contention_rd0 got rdr %b data %h exp 1 %h", m0_readdataready, m0_readdata, ref_mem[12'h020]);
        end
      end
      if (!m1_waitrequest) begin
        gm.push_back(1); gc.push_back(c);
        checks++;
        if (m1_readdataready !== 1'b1 || m1_readdata !== ref_mem[12'h030]) begin
          errors++;
          $display("FAIL contention_rd1 got rdr %b data %h exp 1 %h", m1_readdataready, m1_readdata, ref_mem[12'h030]);
        end
      end
    end
    m0_read = 1'b0; m1_read = 1'b0;
    checks++;
    if (overlap !== 1'b0) begin errors++; $display("FAIL contention_overlap got 1 exp 0"); end
    checks++;
    if (gm.size() != 4) begin
      errors++;
      $display("FAIL contention_count got %0d exp 4", gm.size());
    end else begin
      el = model_last;
      for (int k = 0; k < 4; k++) begin
        el = !el;
        checks++;
        if (gm[k] != int'(el) || gc[k] != (W + 1) + k * (W + 2)) begin
          errors++;
          $display("FAIL contention_grant%0d got m%0d@%0d exp m%0d@%0d", k, gm[k], gc[k], el, (W + 1) + k * (W + 2));
        end
      end
      model_last = el;
    end
    tick();
  endtask

  task automatic test_excl();
    int gm[$];
    int gc[$];
    int n1 = 0;
    int em[3] = '{1, 1, 0};
    int ec[3] = '{3, 7, 11};
    m0_address = 20'h00040; m1_address = 20'h00050;
    excl = 1'b1; m0_read = 1'b1; m1_read = 1'b1;
    for (int c = 1; c <= 16 && gm.size() < 3; c++) begin
      tick();
      if (c == 5) excl = 1'b0;
      if (!m0_waitrequest) begin gm.push_back(0); gc.push_back(c); m0_read = 1'b0; end
      if (!m1_waitrequest) begin
        gm.push_back(1); gc.push_back(c); n1++;
        if (n1 == 2) m1_read = 1'b0;
      end
    end
    m0_read = 1'b0; m1_read = 1'b0; excl = 1'b0;
    checks++;
    if (gm.size() != 3) begin
      errors++;
      $display("FAIL excl_count got %0d exp 3", gm.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gm[k] != em[k] || gc[k] != ec[k]) begin
          errors++;
          $display("FAIL excl_grant%0d got m%0d@%0d exp m%0d@%0d", k, gm[k], gc[k], em[k], ec[k]);
        end
      end
    end
    model_last = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    bit wr_low = 0;
    m1_address = 20'h00800; m1_byteenable = 2'b11; m1_writedata = 16'hA55A; m1_write = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 5'b11111 || busy !== 1'b0 ||
        m1_waitrequest !== 1'b1 || m1_readdataready !== 1'b0 || sram_address !== 20'h0) begin
      errors++;
      $display("FAIL midreset_outputs got strobes %b busy %b wr1 %b rdr1 %b addr %h exp 11111 0 1 0 0",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, busy, m1_waitrequest, m1_readdataready, sram_address);
    end
    checks++;
    if (m0_readdata !== 16'h0) begin errors++; $display("FAIL midreset_readdata got %h exp 0", m0_readdata); end
    reset_n = 1'b1; m1_write = 1'b0;
    ref_write(20'h00800, 16'hA55A, 2'b11);
    model_last = 1'b1;
    repeat (5) begin
      tick();
      if (!m1_waitrequest || !m0_waitrequest) wr_low = 1;
    end
    checks++;
    if (wr_low !== 1'b0) begin errors++; $display("FAIL midreset_no_accept got waitrequest low exp none"); end
  endtask

  task automatic test_random();
    req_t p[2];
    bit v0, v1, quiet, expw, exprd;
    int exp_m, got_m, lat;
    for (int m = 0; m < 2; m++) p[m].v = 0;
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p[m].v && $urandom_range(0, 2) != 0) begin
          int unsigned k = $urandom_range(0, 2);
          p[m].v = 1; p[m].rd = (k != 1); p[m].wr = (k != 0);
          p[m].a = 20'($urandom()); p[m].a[11:6] = '0;
          p[m].be = 2'($urandom()); p[m].d = 16'($urandom());
        end
      end
      excl = ($urandom_range(0, 3) == 0);
      m0_read = p[0].v & p[0].rd; m0_write = p[0].v & p[0].wr;
      m0_address = p[0].a; m0_byteenable = p[0].be; m0_writedata = p[0].d;
      m1_read = p[1].v & p[1].rd; m1_write = p[1].v & p[1].wr;
      m1_address = p[1].a; m1_byteenable = p[1].be; m1_writedata = p[1].d;
      v0 = p[0].v && !excl;
      v1 = p[1].v;
      if (!v0 && !v1) begin
        quiet = 1;
        repeat (3) begin
          tick();
          if (busy || !m0_waitrequest || !m1_waitrequest) quiet = 0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("FAIL rand_idle it%0d got activity exp none", it); end
        excl = 1'b0;
        continue;
      end
      exp_m = (v0 && v1) ? int'(!model_last) : int'(v1);
      expw  = p[exp_m].wr;
      exprd = p[exp_m].rd && !p[exp_m].wr;
      got_m = -1; lat = 0;
      for (int c = 1; c <= 10 && got_m < 0; c++) begin
        tick();
        if (c == 1) begin
          checks++;
          if ({sram_ce_n, sram_oe_n, sram_we_n} !== {1'b0, expw, !expw} ||
              sram_address !== p[exp_m].a || sram_be_n !== ~p[exp_m].be) begin
            errors++;
            $display("FAIL rand_access it%0d got ce/oe/we %b addr %h be_n %b exp %b %h %b", it,
                     {sram_ce_n, sram_oe_n, sram_we_n}, sram_address, sram_be_n,
                     {1'b0, expw, !expw}, p[exp_m].a, ~p[exp_m].be);
          end
        end
        if (!m0_waitrequest || !m1_waitrequest) begin
          got_m = m0_waitrequest ? 1 : 0;
          lat = c;
          checks++;
          if ((!m0_waitrequest && !m1_waitrequest) ||
              {m0_readdataready, m1_readdataready} !== {exprd && exp_m == 0, exprd && exp_m == 1}) begin
            errors++;
            $display("FAIL rand_done_ctl it%0d got wr %b%b rdr %b%b exp m%0d rdr %b", it,
                     m0_waitrequest, m1_waitrequest, m0_readdataready, m1_readdataready, exp_m, exprd);
          end
          if (exprd) begin
            checks++;
            if (m0_readdata !== ref_mem[p[exp_m].a[11:0]]) begin
              errors++;
              $display("FAIL rand_readdata it%0d got %h exp %h", it, m0_readdata, ref_mem[p[exp_m].a[11:0]]);
            end
          end
        end
      end
      checks++;
      if (got_m != exp_m || lat != W + 1) begin
        errors++;
        $display("FAIL rand_grant it%0d got m%0d@%0d exp m%0d@%0d", it, got_m, lat, exp_m, W + 1);
      end
      if (got_m < 0) break;
      if (expw) ref_write(p[exp_m].a, p[exp_m].d, p[exp_m].be);
      p[exp_m].v = 0;
      model_last = exp_m[0];
      if (exp_m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      else begin m1_read = 1'b0; m1_write = 1'b0; end
      tick();
    end
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0; excl = 1'b0;
    repeat (W + 3) tick();
  endtask

  task automatic test_w1_rw_both();
    bit rdr_seen = 0;
    b_m0_address = 20'h00123; b_m0_byteenable = 2'b11; b_m0_writedata = 16'h0F0F;
    b_m0_read = 1'b1; b_m0_write = 1'b1;
    tick();
    if (b_m0_readdataready) rdr_seen = 1;
    checks++;
    if ({b_sram_ce_n, b_sram_oe_n, b_sram_we_n} !== 3'b010 || b_m0_waitrequest !== 1'b1 || b_sram_data !== 16'h0F0F) begin
      errors++;
      $display("FAIL w1_access got ce/oe/we %b wr0 %b data %h exp 010 1 0f0f",
               {b_sram_ce_n, b_sram_oe_n, b_sram_we_n}, b_m0_waitrequest, b_sram_data);
    end
    tick();
    if (b_m0_readdataready) rdr_seen = 1;
    checks++;
    if (b_m0_waitrequest !== 1'b0 || b_sram_we_n !== 1'b1 || b_sram_ce_n !== 1'b0) begin
      errors++;
      $display("FAIL w1_done got wr0 %b we_n %b ce_n %b exp 0 1 0", b_m0_waitrequest, b_sram_we_n, b_sram_ce_n);
    end
    b_m0_read = 1'b0; b_m0_write = 1'b0;
    tick();
    if (b_m0_readdataready) rdr_seen = 1;
    checks++;
    if (rdr_seen !== 1'b0 || b_m0_waitrequest !== 1'b1 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL w1_no_rdr got rdr_seen %b wr0 %b busy %b exp 0 1 0", rdr_seen, b_m0_waitrequest, b_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    reset_n = 1'b0; excl = 1'b0; mem_init = 1'b1;
    m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
    b_m0_address = '0; b_m0_byteenable = '0; b_m0_read = 1'b0; b_m0_write = 1'b0; b_m0_writedata = '0;
    test_reset();
    test_m0_read();
    test_m1_write();
    test_contention();
    test_excl();
    test_reset_mid_write();
    test_random();
    test_w1_rw_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Per-transaction round-robin arbiter and timing sequencer for the board's single asynchronous 16-bit SRAM. It replaces static master selection, so the SoC SRAM conduit (master 0) and the test runner (master 1) can interleave accesses while a run is in progress. It sits between both Avalon-style master ports and the SRAM pins. It drives all SRAM control strobes with a parameterised access length, and can lock the SRAM to the test runner while `excl` is high.

## Interface
- `ADDR_WIDTH`, 20, SRAM word address width
- `DATA_WIDTH`, 16, SRAM data width; byteenable width is `DATA_WIDTH/8`
- `WAIT_CYCLES`, 2, SRAM access cycles per transaction, must be ≥1

Ports:
- `clock`  in  1  single clock for all logic
- `reset_n`  in  1  reset, synchronous, active-low
- `excl`  in  1  high: master 1 exclusive; master 0 is not granted
- `m0_address` / `m1_address`  in  ADDR_WIDTH  word address
- `m0_byteenable` / `m1_byteenable`  in  DATA_WIDTH/8  byte lanes, active-high
- `m0_read` / `m1_read`, `m0_write` / `m1_write`  in  1  request strobes, held until accepted
- `m0_writedata` / `m1_writedata`  in  DATA_WIDTH  write data
- `m0_readdata` / `m1_readdata`  out  DATA_WIDTH  read data, valid with readdataready
- `m0_readdataready` / `m1_readdataready`  out  1  one-cycle read-valid pulse
- `m0_waitrequest` / `m1_waitrequest`  out  1  low for exactly one cycle when the request is accepted
- `busy`  out  1  high whenever the FSM is not in IDLE
- `sram_address`  out  ADDR_WIDTH; `sram_data`  inout  DATA_WIDTH
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1; `sram_be_n`  out  DATA_WIDTH/8

## Operation
- States: IDLE, ACCESS, DONE. There is a `wcnt` counter of width clog2(WAIT_CYCLES+1) and a `last` register for the last granted master.
- IDLE: sample requests (`read|write`) from both masters. A master 0 request is masked when `excl` is 1.
  - One request valid: grant it.
  - Both valid: grant `!last`.
  - On grant: latch the master index, address, byteenable, writedata and direction. Then go to ACCESS and set `wcnt`=WAIT_CYCLES-1.
- Direction: if `write` and `read` are both high, the transaction is a write. No readdataready is issued for it.
- ACCESS: hold for WAIT_CYCLES cycles, decrementing `wcnt`; go to DONE when `wcnt`==0.
  - On the final ACCESS edge of a read, `sram_data` is registered into a shared readdata register.
- DONE: lasts one cycle.
  - The granted master's waitrequest is 0.
  - For a read, that master's readdataready is 1.
  - `last` is updated to the granted index, then the FSM goes to IDLE.
- `excl` is sampled only in IDLE. A master 0 transaction already in flight completes normally.
- Byteenable of all zeros still runs a full cycle, with `sram_be_n` all ones.
- All outputs are registered or decoded from registered state only; no combinational path from master inputs to outputs.

## Timing
- Reset values:
  - SRAM: `sram_ce_n`/`sram_oe_n`/`sram_we_n`=1, `sram_be_n` all 1, `sram_address`=0, `sram_data` Z.
  - Masters: both waitrequest=1, both readdataready=0, readdata=0.
  - Internal: `busy`=0, `last`=1 (master 0 wins the first tie), state IDLE.
- waitrequest is 1 in every cycle except the DONE cycle of that master's grant.
- Latency: request seen in IDLE at cycle 0 → ACCESS cycles 1..W → DONE at cycle W+1 (waitrequest low, readdataready pulse). IDLE resumes at W+2.
- Throughput: one transaction per W+2 cycles, back-to-back without a gap when requests are held.
- SRAM strobes during ACCESS:
  - Always: `sram_ce_n`=0, address and `sram_be_n`=~byteenable driven.
  - Read: `sram_oe_n`=0.
  - Write: `sram_we_n`=0, data driven.
- SRAM strobes during DONE:
  - `sram_we_n` and `sram_oe_n` return to 1.
  - `sram_ce_n`=0, and address and write data are held for hold time.
  - `sram_data` returns to Z on entry to IDLE.
- Readdata stays stable until the next read completes.
- Reset asserted mid-ACCESS or mid-DONE: the next edge returns all outputs to their reset values. The aborted master gets no waitrequest-low and no readdataready.

## Test plan
- **m0 single read, W=2:** m0_read at address 0x00010, SRAM model returns 0xBEEF. Required:
  - `sram_oe_n` low in cycles 1–2.
  - DONE at cycle 3 with m0_waitrequest=0, m0_readdataready=1, m0_readdata=0xBEEF.
- **m1 write, byteenable=2'b01:** m1 writes 0x1234 to address 0xFFFFF. Required:
  - `sram_we_n` low for exactly 2 cycles; `sram_be_n`=2'b10.
  - Data held through DONE; m1_readdataready stays 0.
- **Contention:** both masters hold reads continuously for 4 transactions. Required:
  - Grants go m0, m1, m0, m1.
  - Each is accepted every 4 cycles; no waitrequest-low overlap between masters.
- **Exclusive lock:** excl=1 with both requesting. Required: only m1 is served and m0_waitrequest stays 1. Then drop excl; m0 is granted at the next IDLE.
- **Reset mid-ACCESS of a write:** reset_n=0 in cycle 2. Required:
  - Next cycle: all strobes 1, `sram_data` Z, busy=0.
  - No waitrequest-low to the requester.
- **W=1 build, read+write both asserted:** treated as a write. Required: DONE at cycle 2 and no readdataready.
